// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_pkg
// Description : Shared types, constants and helpers for the 7-segment
//               display scan sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    localparam int N_DIGITS = 8;
    localparam int SEL_W    = 3;

    localparam logic [N_DIGITS-1:0] ANODES_OFF = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } scan_state_t;

    // Active-low anode pattern with only digit s driven low.
    function automatic logic [N_DIGITS-1:0] onehot_low(input logic [SEL_W-1:0] s);
        return ~(N_DIGITS'(1) << s);
    endfunction

    // Lowest set index of mask; 0 when the mask is empty.
    function automatic logic [SEL_W-1:0] lowest_set(input logic [N_DIGITS-1:0] mask);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                r = SEL_W'(i);
            end
        end
        return r;
    endfunction

endpackage : display_pkg
`default_nettype wire

// File: rtl/display_scan_ctrl_next_digit_finder.sv
`default_nettype none
// ============================================================================
// Module      : next_digit_finder
// Description : Combinational search for the next enabled digit after
//               cur_sel, wrapping 7->0. Returns cur_sel when no other
//               digit is enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module next_digit_finder
    import display_pkg::*;
(
    input  logic [SEL_W-1:0]    cur_sel,
    input  logic [N_DIGITS-1:0] mask,
    output logic [SEL_W-1:0]    next_sel
);

    logic [SEL_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest enabled digit wins.
    always_comb begin
        next_sel = cur_sel;
        cand     = '0;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            cand = cur_sel + SEL_W'(i);
            if (mask[cand]) begin
                next_sel = cand;
            end
        end
    end

endmodule : next_digit_finder
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_ctrl
// Description : Scan sequencer for an 8-digit multiplexed 7-segment display.
//               Shows each enabled digit for DIV_COUNT cycles, separated by
//               GAP_CYCLES of all-anodes-off dead time. Outputs registered.
//               Optional build macro DISPLAY_SCAN_DIM_EN adds a 4-bit
//               brightness input driving a 16-step PWM on the lit anode.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int DIV_COUNT  = 100000,
    parameter int DIV_WIDTH  = 17,
    parameter int GAP_CYCLES = 16,
    parameter int GAP_WIDTH  = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [N_DIGITS-1:0] digit_mask,
`ifdef DISPLAY_SCAN_DIM_EN
    input  logic [3:0]          brightness,
`endif
    output logic [SEL_W-1:0]    sel,
    output logic [N_DIGITS-1:0] anodes,
    output logic                frame_done
);

    localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(DIV_COUNT - 1);
    localparam logic [GAP_WIDTH-1:0] GAP_LAST = GAP_WIDTH'(GAP_CYCLES - 1);

    scan_state_t          state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [N_DIGITS-1:0]  anodes_q, anodes_d;
    logic                 frame_done_q, frame_done_d;
    logic [DIV_WIDTH-1:0] presc_q, presc_d;
    logic [GAP_WIDTH-1:0] gap_q, gap_d;
    logic [SEL_W-1:0]     next_sel;
    logic                 lit_ok;

    next_digit_finder u_next_digit_finder (
        .cur_sel  (sel_q),
        .mask     (digit_mask),
        .next_sel (next_sel)
    );

`ifdef DISPLAY_SCAN_DIM_EN
    logic [3:0] pwm_q, pwm_d;

    // Anodes are registered, so gate with the PWM value of the coming cycle.
    always_comb begin
        pwm_d  = pwm_q + 4'd1;
        lit_ok = (pwm_d <= brightness);
    end
`else
    // Without dimming the selected digit is lit for the whole SHOW period.
    always_comb begin
        lit_ok = 1'b1;
    end
`endif

    // Next-state, counter and output decode; disable/empty mask wins over all.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        anodes_d     = ANODES_OFF;
        frame_done_d = 1'b0;
        presc_d      = presc_q;
        gap_d        = gap_q;
        if (!en || digit_mask == '0) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    sel_d    = lowest_set(digit_mask);
                    presc_d  = '0;
                    state_d  = SHOW;
                    anodes_d = lit_ok ? onehot_low(sel_d) : ANODES_OFF;
                end
                SHOW: begin
                    if (!digit_mask[sel_q] || presc_q == DIV_LAST) begin
                        // Digit removed from the scan ends its period early.
                        state_d = GAP;
                        gap_d   = '0;
                    end else begin
                        presc_d  = presc_q + DIV_WIDTH'(1);
                        anodes_d = lit_ok ? onehot_low(sel_q) : ANODES_OFF;
                    end
                end
                GAP: begin
                    if (gap_q == GAP_LAST) begin
                        sel_d        = next_sel;
                        presc_d      = '0;
                        state_d      = SHOW;
                        frame_done_d = (next_sel <= sel_q);
                        anodes_d     = lit_ok ? onehot_low(next_sel) : ANODES_OFF;
                    end else begin
                        gap_d = gap_q + GAP_WIDTH'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            anodes_q     <= ANODES_OFF;
            frame_done_q <= 1'b0;
            presc_q      <= '0;
            gap_q        <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            anodes_q     <= anodes_d;
            frame_done_q <= frame_done_d;
            presc_q      <= presc_d;
            gap_q        <= gap_d;
        end
    end

`ifdef DISPLAY_SCAN_DIM_EN
    // Free-running PWM phase counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_d;
        end
    end
`endif

    assign sel        = sel_q;
    assign anodes     = anodes_q;
    assign frame_done = frame_done_q;

endmodule : display_scan_ctrl
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scan_ctrl
// Description : Scoreboard bench for display_scan_ctrl with DIV_COUNT=4 and
//               GAP_CYCLES=2. Stimulus pushes one expected output word per
//               clock; a monitor pops and compares on every falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_ctrl;

    localparam int DIV  = 4;
    localparam int GAPC = 2;

    typedef struct packed {
        logic [2:0] sel;
        logic [7:0] an;
        logic       fd;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [7:0] digit_mask;
    logic [2:0] sel;
    logic [7:0] anodes;
    logic       frame_done;
`ifdef DISPLAY_SCAN_DIM_EN
    logic [3:0] brightness = 4'd15;
`endif

    exp_t  q[$];
    int    checks = 0;
    int    errors = 0;
    string phase  = "reset";

    display_scan_ctrl #(
        .DIV_COUNT  (DIV),
        .DIV_WIDTH  (3),
        .GAP_CYCLES (GAPC),
        .GAP_WIDTH  (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .digit_mask (digit_mask),
`ifdef DISPLAY_SCAN_DIM_EN
        .brightness (brightness),
`endif
        .sel        (sel),
        .anodes     (anodes),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] oh(input int d);
        logic [7:0] one;
        one = 8'b1;
        return ~(one << d);
    endfunction

    task automatic push(input int s, input logic [7:0] a, input logic f, input int n);
        exp_t e;
        e.sel = 3'(s);
        e.an  = a;
        e.fd  = f;
        for (int i = 0; i < n; i++) q.push_back(e);
    endtask

    // One full digit period: SHOW then GAP. frame_done only on wrap from GAP.
    task automatic push_digit(input int d, input int prev, input bit from_idle);
        push(d, oh(d), (!from_idle && d <= prev), 1);
        push(d, oh(d), 1'b0, DIV - 1);
        push(d, 8'hFF, 1'b0, GAPC);
    endtask

    // Let the queued expectations drain; leaves us just after a falling edge.
    task automatic step_all();
        int n;
        n = q.size();
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Monitor: one comparison per cycle while expectations are pending.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (sel !== e.sel || anodes !== e.an || frame_done !== e.fd) begin
                errors++;
                $display("FAIL %s t=%0t: got sel=%0d anodes=%h fd=%b, expected sel=%0d anodes=%h fd=%b",
                         phase, $time, sel, anodes, frame_done, e.sel, e.an, e.fd);
            end
        end
    end

    initial begin
        int seq3[3];
        seq3 = '{2, 5, 7};

        // Reset held for three cycles.
        reset = 1'b1; en = 1'b1; digit_mask = 8'hFF;
        push(0, 8'hFF, 1'b0, 3);
        step_all();
        reset = 1'b0;

        // Full mask: two frames plus the wrap into a third.
        phase = "full_scan";
        for (int k = 0; k < 17; k++)
            push_digit(k % 8, (k == 0) ? 0 : (k - 1) % 8, k == 0);
        step_all();

        // Sparse mask, changed during the last GAP cycle of digit 0.
        phase = "sparse_scan";
        digit_mask = 8'b1010_0100;
        for (int k = 0; k < 7; k++)
            push_digit(seq3[k % 3], (k == 0) ? 0 : seq3[(k + 2) % 3], 1'b0);
        step_all();

        // Single digit: wraps onto itself every period.
        phase = "single_digit";
        digit_mask = 8'h10;
        push_digit(4, 2, 1'b0);
        for (int k = 0; k < 3; k++) push_digit(4, 4, 1'b0);
        step_all();

        // Clear the shown digit's mask bit mid-SHOW.
        phase = "mask_drop";
        digit_mask = 8'h08;
        push(3, oh(3), 1'b1, 1);
        push(3, oh(3), 1'b0, 1);
        step_all();
        digit_mask = 8'h01;
        push(3, 8'hFF, 1'b0, GAPC);
        push_digit(0, 3, 1'b0);
        step_all();

        // Drop enable mid-SHOW, then re-enable on a new mask.
        phase = "en_drop";
        push(0, oh(0), 1'b1, 1);
        push(0, oh(0), 1'b0, 1);
        step_all();
        en = 1'b0;
        push(0, 8'hFF, 1'b0, 3);
        step_all();
        phase = "en_rise";
        en = 1'b1; digit_mask = 8'h30;
        push_digit(4, 0, 1'b1);
        push_digit(5, 4, 1'b0);
        step_all();

        // Empty mask forces IDLE with sel held.
        phase = "mask_zero";
        digit_mask = 8'h00;
        push(5, 8'hFF, 1'b0, 2);
        step_all();

        // Reset asserted mid-SHOW.
        phase = "mid_reset";
        digit_mask = 8'h80;
        push(7, oh(7), 1'b0, 2);
        step_all();
        reset = 1'b1;
        push(0, 8'hFF, 1'b0, 2);
        step_all();
        reset = 1'b0;
        push_digit(7, 0, 1'b1);
        step_all();

        phase = "drain";
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, expected 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_display_scan_ctrl
`default_nettype wire
